// File: rtl/fk_hist_seq_pkg.sv
// Shared definitions for the fk sample-history sequencer and its tap mux:
// default sample width, sequencer state encoding, tap select codes and the
// Moore output decode.
package fk_hist_seq_pkg;

  localparam int W_DEFAULT = 25;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Tap select codes, shared with the downstream fk mux.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_FK   = 2'b01;
  localparam logic [1:0] SEL_FK1  = 2'b10;
  localparam logic [1:0] SEL_FK2  = 2'b11;

  typedef struct packed {
    logic [1:0] select;
    logic       acc_clr;
    logic       acc_en;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Control outputs that belong to a given state.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      T0: begin
        c.select  = SEL_FK;
        c.acc_clr = 1'b1;
        c.acc_en  = 1'b1;
        c.busy    = 1'b1;
      end
      T1: begin
        c.select = SEL_FK1;
        c.acc_en = 1'b1;
        c.busy   = 1'b1;
      end
      T2: begin
        c.select = SEL_FK2;
        c.acc_en = 1'b1;
        c.busy   = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fk_hist_seq_if.sv
// Sample input and tap/strobe output bundle between the sample source,
// the history sequencer and the downstream mux/accumulator.
interface fk_hist_seq_if #(
  parameter int W = fk_hist_seq_pkg::W_DEFAULT
);

  logic         sample_tick;
  logic [W-1:0] x_in;
  logic [W-1:0] fk;
  logic [W-1:0] fk_1;
  logic [W-1:0] fk_2;
  logic [1:0]   select;
  logic         acc_clr;
  logic         acc_en;
  logic         busy;
  logic         done;
  logic         overrun;

  // Sample source / observer side.
  modport master (
    output sample_tick, x_in,
    input  fk, fk_1, fk_2, select, acc_clr, acc_en, busy, done, overrun
  );

  // Sequencer side.
  modport slave (
    input  sample_tick, x_in,
    output fk, fk_1, fk_2, select, acc_clr, acc_en, busy, done, overrun
  );

endinterface

// File: rtl/fk_hist_seq_delay_line.sv
// Three-stage W-bit sample history: on load, every stage moves one step
// older and the new sample enters stage 0.
module fk_delay_line
  import fk_hist_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2
);

  // Shift the history by one sample on each load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments let every stage capture its
      // predecessor's old value on the same edge, so the order of these
      // lines does not matter.
      q2 <= q1;
      q1 <= q0;
      q0 <= d;
    end
  end

endmodule

// File: rtl/fk_hist_seq.sv
// Sample-history and tap sequencer feeding the fk tap mux: keeps the last
// three samples and steps the mux select through them one tap per clock,
// with accumulator strobes for the downstream multiply-accumulate.
module fk_hist_seq
  import fk_hist_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fk_hist_seq_if.slave  bus
);

  state_t       state;
  state_t       next_state;
  logic         accept;
  logic         overrun_set;
  ctrl_t        ctrl_q;
  logic         overrun_q;
  logic [W-1:0] fk_q;
  logic [W-1:0] fk_1_q;
  logic [W-1:0] fk_2_q;

  fk_delay_line #(.W(W)) u_delay_line (
    .clk   (clk),
    .rst_n (reset),
    .load  (accept),
    .d     (bus.x_in),
    .q0    (fk_q),
    .q1    (fk_1_q),
    .q2    (fk_2_q)
  );

  // Next-state logic: a sample is taken only while idle or in the final cycle.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it
    // unassigned and no latch is inferred.
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_tick) begin
          accept     = 1'b1;
          next_state = T0;
        end
      end
      T0: next_state = T1;
      T1: next_state = T2;
      T2: next_state = DONE;
      DONE: begin
        if (bus.sample_tick) begin
          accept     = 1'b1;
          next_state = T0;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A tick arriving mid-sequence is dropped and flagged.
  assign overrun_set = bus.sample_tick && (state inside {T0, T1, T2});

  // State register, registered Moore outputs and sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= next_state;
      ctrl_q    <= decode_ctrl(next_state);
      overrun_q <= overrun_q | overrun_set;
    end
  end

  assign bus.fk      = fk_q;
  assign bus.fk_1    = fk_1_q;
  assign bus.fk_2    = fk_2_q;
  assign bus.select  = ctrl_q.select;
  assign bus.acc_clr = ctrl_q.acc_clr;
  assign bus.acc_en  = ctrl_q.acc_en;
  assign bus.busy    = ctrl_q.busy;
  assign bus.done    = ctrl_q.done;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_fk_hist_seq.sv
// Directed bench for fk_hist_seq: per-cycle control checks plus a history
// scoreboard filled on each accepted tick and drained on each done pulse.
module tb_fk_hist_seq;
  import fk_hist_seq_pkg::*;

  localparam int W = W_DEFAULT;

  typedef struct packed {
    logic [W-1:0] h0;
    logic [W-1:0] h1;
    logic [W-1:0] h2;
  } hist_t;

  logic clk = 1'b0;
  logic rst_n;

  fk_hist_seq_if #(.W(W)) bus ();

  fk_hist_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    done_count = 0;
  hist_t sb[$];
  logic [W-1:0] m0, m1, m2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m0 = '0;
    m1 = '0;
    m2 = '0;
    sb.delete();
  endtask

  task automatic model_accept(input logic [W-1:0] x);
    m2 = m1;
    m1 = m0;
    m0 = x;
    sb.push_back({m0, m1, m2});
  endtask

  // Drive a tick for one edge; returns in the T0 cycle.
  task automatic accept(input logic [W-1:0] x);
    bus.sample_tick = 1'b1;
    bus.x_in        = x;
    model_accept(x);
    step();
    bus.sample_tick = 1'b0;
  endtask

  task automatic expect_ctrl(input string tag, input logic [1:0] sel, input logic clr,
                             input logic en, input logic bsy, input logic dn);
    check({tag, "_select"},  32'(bus.select),  32'(sel));
    check({tag, "_acc_clr"}, 32'(bus.acc_clr), 32'(clr));
    check({tag, "_acc_en"},  32'(bus.acc_en),  32'(en));
    check({tag, "_busy"},    32'(bus.busy),    32'(bsy));
    check({tag, "_done"},    32'(bus.done),    32'(dn));
  endtask

  task automatic expect_hist(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] c);
    check({tag, "_fk"},   32'(bus.fk),   32'(a));
    check({tag, "_fk_1"}, 32'(bus.fk_1), 32'(b));
    check({tag, "_fk_2"}, 32'(bus.fk_2), 32'(c));
  endtask

  task automatic expect_all_zero(input string tag);
    expect_ctrl(tag, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_hist(tag, '0, '0, '0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
  endtask

  // Full sequence from an accept; returns in the DONE cycle.
  task automatic run_seq(input string tag, input logic [W-1:0] x);
    accept(x);
    expect_ctrl({tag, "_t0"}, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    expect_ctrl({tag, "_t1"}, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_ctrl({tag, "_t2"}, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_ctrl({tag, "_done"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Scoreboard drain: each done pulse must present the next expected history.
  always @(negedge clk) begin
    hist_t e;
    if (rst_n && bus.done) begin
      done_count++;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      check("sb_fk",   32'(bus.fk),   32'(e.h0));
      check("sb_fk_1", 32'(bus.fk_1), 32'(e.h1));
      check("sb_fk_2", 32'(bus.fk_2), 32'(e.h2));
    end
  end

  initial begin
    int done_before;
    rst_n           = 1'b0;
    bus.sample_tick = 1'b0;
    bus.x_in        = '0;
    model_reset();
    repeat (2) step();
    expect_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single sample from reset.
    expect_ctrl("single_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    accept(25'h0000005);
    expect_ctrl("single_t0", 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_hist("single", 25'h0000005, '0, '0);
    step();
    expect_ctrl("single_t1", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_ctrl("single_t2", 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    expect_ctrl("single_done", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    expect_ctrl("single_after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // History shift across three separate sequences.
    run_seq("hist1", 25'd1);
    step();
    run_seq("hist2", 25'd2);
    step();
    run_seq("hist3", 25'd3);
    expect_hist("hist3", 25'd3, 25'd2, 25'd1);

    // Back-to-back accept in the DONE cycle, full-width value.
    run_seq("b2b", 25'h1FFFFFF);
    expect_hist("b2b", 25'h1FFFFFF, 25'd3, 25'd2);
    check("b2b_overrun", 32'(bus.overrun), 32'd0);
    step();
    expect_ctrl("b2b_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Tick during T1 is dropped and flags overrun.
    accept(25'd7);
    expect_ctrl("ovr_t0", 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    expect_ctrl("ovr_t1", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovr_before", 32'(bus.overrun), 32'd0);
    bus.sample_tick = 1'b1;
    bus.x_in        = 25'd9;
    step();
    bus.sample_tick = 1'b0;
    expect_ctrl("ovr_t2", 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_hist("ovr_t2", 25'd7, 25'h1FFFFFF, 25'd3);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    step();
    expect_ctrl("ovr_done", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    expect_ctrl("ovr_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Tick held high for 16 cycles: one accept every fourth edge.
    done_before = done_count;
    for (int i = 0; i < 16; i++) begin
      bus.sample_tick = 1'b1;
      bus.x_in        = W'(100 + i);
      if (i % 4 == 0) model_accept(W'(100 + i));
      step();
    end
    bus.sample_tick = 1'b0;
    step();
    check("cont_done_pulses", 32'(done_count - done_before), 32'd4);
    check("cont_sb_drained", 32'(sb.size()), 32'd0);
    check("cont_overrun", 32'(bus.overrun), 32'd1);
    expect_hist("cont", 25'd112, 25'd108, 25'd104);

    // Asynchronous reset in the middle of a sequence.
    accept(25'h0000123);
    step();
    expect_ctrl("rst_mid_t1", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_all_zero("rst_async");
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    expect_all_zero("rst_release");

    // Recovery after reset.
    run_seq("recover", 25'h0000005);
    expect_hist("recover", 25'h0000005, '0, '0);
    step();
    check("end_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
